// File: rtl/rr_mux16_scheduler_pkg.sv
// Shared types and sizes for the 16-requester round-robin bit-mux scheduler.
package mux16_pkg;
    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/rr_mux16_scheduler_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at 15.
module rr_pick16
    import mux16_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from farthest to nearest so the nearest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux16_scheduler.sv
// Round-robin owner of the shared serial line: grants bursts of up to BURST_LEN beats.
//   state | meaning
//   IDLE  | no owner, grant=0, waiting for any request
//   BUSY  | sel/grant hold the owner, beats flow while req[sel] stays high
module rr_mux16_scheduler
    import mux16_pkg::*;
#(
    parameter  int BURST_LEN = 4,
    localparam int CNT_W     = $clog2(BURST_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             out_valid,
    output logic             out_bit,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] beat_cnt, cnt_nxt;

    logic             busy;
    logic             xfer;
    logic             last_beat;
    logic             burst_end;
    logic [SEL_W-1:0] sel_inc;
    logic [SEL_W-1:0] pick_ptr;
    logic             found;
    logic [SEL_W-1:0] idx;

    assign busy      = (state == BUSY);
    assign xfer      = busy && req[sel] && out_ready;
    assign last_beat = xfer && (beat_cnt == LAST_BEAT);
    assign burst_end = busy && (last_beat || !req[sel]);
    assign sel_inc   = sel + SEL_W'(1);
    // At burst end the search already starts past the outgoing owner.
    assign pick_ptr  = burst_end ? sel_inc : ptr;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (idx)
    );

    assign out_bit = data_in[sel];

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        cnt_nxt   = beat_cnt;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    sel_nxt   = idx;
                    grant_nxt = N_REQ'(1) << idx;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                out_valid = req[sel];
                done      = last_beat;
                if (burst_end) begin
                    ptr_nxt = sel_inc;
                    cnt_nxt = '0;
                    if (found) begin
                        sel_nxt   = idx;
                        grant_nxt = N_REQ'(1) << idx;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (xfer) begin
                    cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            grant    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

endmodule
